ir_queue: RTL
=============

// Module: ir_queue
// PURPOSE
// - Parametrised instruction buffer with field decode; the successor to the single-entry IR.
// - Holds up to DEPTH fetched instruction words in FIFO order.
// - Presents the head entry plus its LC-3b decoded fields to the control/datapath.
// - Sits between the memory fetch path and the decode/control FSM.
// PARAMETERS
// - WIDTH  16  Instruction word width. Must be >= 16; fields decode from bits [15:0].
// - DEPTH  4   Number of entries. Power of two, >= 2.
// PORTS
// - clk        in   1          Clock, rising edge.
// - rst_n      in   1          Asynchronous active-low reset.
// - flush      in   1          Synchronous discard of all entries.
// - in_valid   in   1          Fetch word valid.
// - in_data    in   WIDTH      Fetch word.
// - in_ready   out  1          Queue can accept a word.
// - out_valid  out  1          Head entry valid.
// - out_ready  in   1          Consumer pops the head.
// - out_data   out  WIDTH      Head word.
// - count      out  CW         Occupancy; CW = $clog2(DEPTH+1).
// - opcode     out  4          Head [15:12].
// - dest       out  3          Head [11:9].
// - src1       out  3          Head [8:6].
// - src2       out  3          Head [2:0].
// - offset6 / offset9 / offset11  out  6/9/11  Head [5:0] / [8:0] / [10:0].
// - trapvect8 / imm5 / imm4       out  8/5/4   Head [7:0] / [4:0] / [3:0].
// - bit11, bit5, a, d             out  1 each  Head [11], [5], [5], [4].
// BEHAVIOUR
// - Reset (async, rst_n=0): rd/wr pointers=0, count=0, out_valid=0, in_ready=1.
//   out_data and all field ports=0. Storage array is not reset.
// - push = in_valid & in_ready; pop = out_valid & out_ready; both act on the rising edge.
// - in_ready = (count != DEPTH). No write when full, even with a same-cycle pop.
// - out_valid = (count != 0).
// - out_data/fields: combinational from mem[rd_ptr]; forced to 0 when out_valid=0.
// - Push only: write at wr_ptr, wr_ptr++, count++.
// - Pop only: rd_ptr++, count--.
// - Push and pop together: both pointers advance, count unchanged.
// - Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
// - flush: next edge sets pointers=0, count=0. Overrides same-cycle push and pop.
//   in_data is discarded; a popped head is still considered consumed by the consumer.
// - Latency: push to out_valid = 1 cycle (entry visible the cycle after the push edge).
// - Ordering: strict FIFO; no entry is lost or duplicated across wrap-around.
// - rst_n asserted mid-operation: immediate return to reset values; contents are abandoned.
// CONFIGURATION
// - IR_QUEUE_BYPASS_EN defined: when count==0 and in_valid=1 and flush=0:
//   - out_valid=1; out_data and fields come combinationally from in_data.
//   - If out_ready=1 too, the word is consumed and not written (count stays 0).
//   - Otherwise it is written normally.
//   - Zero-cycle latency on an empty queue.
// - IR_QUEUE_BYPASS_EN undefined: no bypass; out_valid depends on count only.
// TESTING
// - Reset, then push 16'h1A45 -> next cycle: out_valid=1, opcode=4'h1, dest=3'd5,
//   src1=3'd1, src2=3'd5, imm5=5'h05, a=0, bit5=0, count=1.
// - Push 16'h0001..16'h0004 with DEPTH=4, out_ready=0 -> count=4, in_ready=0.
//   A 5th push is ignored; popping yields 0001..0004 in order.
// - Keep push and pop together continuously for 10 cycles at count=2 -> count stays 2;
//   pointers wrap; output sequence matches input order.
// - Full queue, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0,
//   out_valid=0, out_data=0, in_ready=1.
// - Drop rst_n while count=3 -> count=0, out_valid=0 with no clock edge.
// - BYPASS_EN: empty queue, in_data=16'hF025, in_valid=1, out_ready=1 -> same cycle
//   out_valid=1, opcode=4'hF, trapvect8=8'h25; next cycle count=0.

Source files
------------

// File: rtl/ir_queue.sv
// Instruction queue: DEPTH-entry FIFO of fetched words with LC-3b field decode of the head.
// Optional empty-queue bypass of in_data to the head is enabled by defining IR_QUEUE_BYPASS_EN.
module ir_queue #(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count,
   output logic [3:0]       opcode,
   output logic [2:0]       dest,
   output logic [2:0]       src1,
   output logic [2:0]       src2,
   output logic [5:0]       offset6,
   output logic [8:0]       offset9,
   output logic [10:0]      offset11,
   output logic [7:0]       trapvect8,
   output logic [4:0]       imm5,
   output logic [3:0]       imm4,
   output logic             bit11,
   output logic             bit5,
   output logic             a,
   output logic             d
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             empty;
   logic             byp;
   logic             byp_take;
   logic             push;
   logic             pop;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] head;
   logic [15:0]      hd;

   // Handshake, head selection and the effective write/advance enables
   always_comb begin
      empty    = (count == '0);
      in_ready = (count != CW'(DEPTH));
`ifdef IR_QUEUE_BYPASS_EN
      byp      = empty & in_valid & ~flush;
`else
      byp      = 1'b0;
`endif
      out_valid = ~empty | byp;
      head      = byp ? in_data : mem[rd_ptr];
      out_data  = out_valid ? head : '0;
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      // A bypassed word taken in the same cycle never touches storage
      byp_take  = byp & out_ready;
      wr_en     = push & ~byp_take & ~flush;
      rd_en     = pop & ~byp_take & ~flush;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

   // LC-3b field decode of the (already zero-forced) head word
   always_comb begin
      hd        = out_data[15:0];
      opcode    = hd[15:12];
      dest      = hd[11:9];
      src1      = hd[8:6];
      src2      = hd[2:0];
      offset6   = hd[5:0];
      offset9   = hd[8:0];
      offset11  = hd[10:0];
      trapvect8 = hd[7:0];
      imm5      = hd[4:0];
      imm4      = hd[3:0];
      bit11     = hd[11];
      bit5      = hd[5];
      a         = hd[5];
      d         = hd[4];
   end

endmodule
